calc_history_ctrl: RTL and testbench

Controller that sits directly upstream of the calculator's result memory (8 × 17-bit, registered read, `ReadWrite`=1 read / 0 write). It stores each new calculator result into the memory as a circular history and serves indexed recall requests ("n-th most recent result"). It owns the memory's `enable`, `ReadWrite`, `Address` and `DataIn` pins, and samples its `DataOut`.

---
 rtl/calc_history_ctrl_if.sv | 41 ++++
 rtl/calc_history_ctrl.sv | 147 ++++++++++++++
 tb/tb_calc_history_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_history_ctrl_if.sv
// ============================================================================
// Module   : calc_history_ctrl_if
// Purpose  : Request/recall bus and result-memory pins of the history controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface calc_history_ctrl_if #(
  parameter int N = 17,
  parameter int M = 3
);
  logic         store_req;
  logic [N-1:0] store_data;
  logic         recall_req;
  logic [M-1:0] recall_idx;
  logic         clear;
  logic         busy;
  logic         recall_valid;
  logic [N-1:0] recall_data;
  logic         recall_err;
  logic [M:0]   count;
  logic         mem_enable;
  logic         mem_rw;
  logic [M-1:0] mem_addr;
  logic [N-1:0] mem_din;
  logic [N-1:0] mem_dout;

  modport slave (
    input  store_req, store_data, recall_req, recall_idx, clear, mem_dout,
    output busy, recall_valid, recall_data, recall_err, count,
           mem_enable, mem_rw, mem_addr, mem_din
  );

  modport master (
    output store_req, store_data, recall_req, recall_idx, clear, mem_dout,
    input  busy, recall_valid, recall_data, recall_err, count,
           mem_enable, mem_rw, mem_addr, mem_din
  );
endinterface

`default_nettype wire

// File: rtl/calc_history_ctrl.sv
// ============================================================================
// Module   : calc_history_ctrl
// Purpose  : Circular result history in an 8x17 registered-read memory with
//            indexed recall (0 = most recent).
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_history_ctrl #(
  parameter int N = 17,
  parameter int M = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  calc_history_ctrl_if.slave  bus
);

  localparam int           DEPTH   = 1 << M;
  localparam logic [M:0]   C_DEPTH = DEPTH[M:0];
  localparam logic [M-1:0] C_ONE_P = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M:0]   C_ONE_C = {{M{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RDW  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [M-1:0] r_wptr;
  logic [M-1:0] r_raddr;
  logic [M:0]   r_count;
  logic [N-1:0] r_wdata;
  logic [N-1:0] r_rdata;
  logic         r_valid;
  logic         r_err;

  logic         w_idle;
  logic         w_idx_bad;
  logic         w_do_clear;
  logic         w_do_store;
  logic         w_do_recall;
  logic [M-1:0] w_raddr;
  logic         w_mem_enable;
  logic         w_mem_rw;

  assign w_idle      = (r_state == S_IDLE);
  assign w_idx_bad   = ({1'b0, bus.recall_idx} >= r_count);
  // clear > store > recall; losers in the same cycle are simply dropped
  assign w_do_clear  = w_idle & bus.clear;
  assign w_do_store  = w_idle & ~bus.clear & bus.store_req;
  assign w_do_recall = w_idle & ~bus.clear & ~bus.store_req & bus.recall_req;
  assign w_raddr     = r_wptr - C_ONE_P - bus.recall_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_enable = 1'b0;
    w_mem_rw     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_do_store) begin
          w_next = S_WR;
        end else if (w_do_recall && !w_idx_bad) begin
          w_next = S_RD;
        end
      end
      S_WR: begin
        w_mem_enable = 1'b1;
        w_mem_rw     = 1'b0;
        w_next       = S_IDLE;
      end
      S_RD: begin
        w_mem_enable = 1'b1;
        w_next       = S_RDW;
      end
      S_RDW: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_raddr <= '0;
      r_count <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_do_clear) begin
        r_count <= '0;
        r_wptr  <= '0;
      end
      if (w_do_store) begin
        r_wdata <= bus.store_data;
      end
      if (w_do_recall) begin
        if (w_idx_bad) begin
          r_err <= 1'b1;
        end else begin
          r_raddr <= w_raddr;
        end
      end
      if (r_state == S_WR) begin
        r_wptr <= r_wptr + C_ONE_P;
        if (r_count != C_DEPTH) begin
          r_count <= r_count + C_ONE_C;
        end
      end
      // DataOut is only driven in the cycle after a read-enabled edge
      if (r_state == S_RDW) begin
        r_rdata <= bus.mem_dout;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.busy         = ~w_idle;
  assign bus.recall_valid = r_valid;
  assign bus.recall_err   = r_err;
  assign bus.recall_data  = r_rdata;
  assign bus.count        = r_count;
  assign bus.mem_enable   = w_mem_enable;
  assign bus.mem_rw       = w_mem_rw;
  assign bus.mem_addr     = (r_state == S_RD) ? r_raddr : r_wptr;
  assign bus.mem_din      = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_calc_history_ctrl.sv
// ============================================================================
// Module   : tb_calc_history_ctrl
// Purpose  : Self-checking bench with a queue-based history model and a
//            registered-read memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_calc_history_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [16:0] hist[$];
  int          wptr_m = 0;

  logic [16:0] mem [8];
  logic [16:0] mem_q;

  calc_history_ctrl_if #(.N(17), .M(3)) bus ();

  calc_history_ctrl #(.N(17), .M(3)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Result memory: registered read, high-Z after a disabled edge
  always @(posedge clk) begin
    if (bus.mem_enable) begin
      if (!bus.mem_rw) mem[bus.mem_addr] <= bus.mem_din;
      else             mem_q <= mem[bus.mem_addr];
    end else begin
      mem_q <= 'z;
    end
  end
  assign bus.mem_dout = mem_q;

  function automatic void model_store(input logic [16:0] d);
    hist.push_front(d);
    if (hist.size() > 8) void'(hist.pop_back());
    wptr_m = (wptr_m + 1) % 8;
  endfunction

  function automatic void model_clear();
    hist.delete();
    wptr_m = 0;
  endfunction

  task automatic apply_reset();
    bus.store_req = 1'b0; bus.recall_req = 1'b0; bus.clear = 1'b0;
    bus.store_data = '0;  bus.recall_idx = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
  endtask

  task automatic op_store(input logic [16:0] d, output logic [2:0] a, output logic [16:0] din,
                          output logic en, output logic rw, output logic bsy);
    @(negedge clk); bus.store_req = 1'b1; bus.store_data = d;
    @(posedge clk); #1;
    a = bus.mem_addr; din = bus.mem_din; en = bus.mem_enable; rw = bus.mem_rw; bsy = bus.busy;
    @(negedge clk); bus.store_req = 1'b0;
    @(posedge clk); #1;
    model_store(d);
  endtask

  task automatic op_recall(input logic [2:0] idx, output int n_err, output int n_valid,
                           output int lat, output logic [16:0] data, output logic [2:0] a,
                           output logic en);
    @(negedge clk); bus.recall_req = 1'b1; bus.recall_idx = idx;
    @(posedge clk); #1;
    n_err = int'(bus.recall_err); n_valid = int'(bus.recall_valid);
    a = bus.mem_addr; en = bus.mem_enable; lat = -1; data = '0;
    @(negedge clk); bus.recall_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (bus.recall_err) n_err++;
      if (bus.recall_valid) begin
        n_valid++;
        if (lat < 0) begin lat = k; data = bus.recall_data; end
      end
    end
  endtask

  task automatic op_clear();
    @(negedge clk); bus.clear = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); bus.clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.recall_valid !== 1'b0 || bus.recall_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", bus.recall_valid, bus.recall_err); end
    checks++; if (bus.recall_data !== 17'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.recall_data); end
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.mem_enable !== 1'b0 || bus.mem_rw !== 1'b1) begin failures++; $display("FAIL reset_mem_ctl got en=%b rw=%b exp en=0 rw=1", bus.mem_enable, bus.mem_rw); end
    checks++; if (bus.mem_addr !== 3'd0 || bus.mem_din !== 17'h0) begin failures++; $display("FAIL reset_mem_bus got addr=%0d din=%h exp 0/0", bus.mem_addr, bus.mem_din); end
  endtask

  task automatic test_empty_recall();
    int ne, nv, lat; logic [16:0] d; logic [2:0] a; logic en;
    op_recall(3'd0, ne, nv, lat, d, a, en);
    checks++; if (ne !== 1 || nv !== 0) begin failures++; $display("FAIL empty_recall got err=%0d valid=%0d exp err=1 valid=0", ne, nv); end
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL empty_recall_en got=%b exp=0", en); end
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL empty_recall_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_store_recall();
    int ne, nv, lat; logic [16:0] d, din; logic [2:0] a; logic en, rw, bsy;
    op_store(17'h12345, a, din, en, rw, bsy);
    checks++; if (a !== 3'd0 || din !== 17'h12345) begin failures++; $display("FAIL store_bus got addr=%0d din=%h exp 0/12345", a, din); end
    checks++; if (en !== 1'b1 || rw !== 1'b0 || bsy !== 1'b1) begin failures++; $display("FAIL store_ctl got en=%b rw=%b busy=%b exp 1/0/1", en, rw, bsy); end
    checks++; if (bus.count !== 4'd1 || bus.busy !== 1'b0) begin failures++; $display("FAIL store_count got count=%0d busy=%b exp 1/0", bus.count, bus.busy); end
    op_recall(3'd0, ne, nv, lat, d, a, en);
    checks++; if (nv !== 1 || ne !== 0 || lat !== 2) begin failures++; $display("FAIL recall_pulse got valid=%0d err=%0d lat=%0d exp 1/0/2", nv, ne, lat); end
    checks++; if (d !== 17'h12345) begin failures++; $display("FAIL recall_data got=%h exp=12345", d); end
    checks++; if (a !== 3'd0 || en !== 1'b1) begin failures++; $display("FAIL recall_addr got addr=%0d en=%b exp 0/1", a, en); end
    checks++; if (bus.recall_data !== 17'h12345) begin failures++; $display("FAIL recall_hold got=%h exp=12345", bus.recall_data); end
  endtask

  task automatic test_wrap();
    int ne, nv, lat; logic [16:0] d, din; logic [2:0] a; logic en, rw, bsy;
    apply_reset();
    for (int i = 10; i <= 19; i++) op_store(17'(i), a, din, en, rw, bsy);
    checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL wrap_count got=%0d exp=8", bus.count); end
    op_recall(3'd0, ne, nv, lat, d, a, en);
    checks++; if (a !== 3'd1 || d !== 17'd19 || nv !== 1) begin failures++; $display("FAIL wrap_idx0 got addr=%0d data=%0d valid=%0d exp 1/19/1", a, d, nv); end
    op_recall(3'd7, ne, nv, lat, d, a, en);
    checks++; if (a !== 3'd2 || d !== 17'd12 || nv !== 1) begin failures++; $display("FAIL wrap_idx7 got addr=%0d data=%0d valid=%0d exp 2/12/1", a, d, nv); end
    op_store(17'h1abcd, a, din, en, rw, bsy);
    checks++; if (a !== 3'd2 || bus.count !== 4'd8) begin failures++; $display("FAIL wrap_next got addr=%0d count=%0d exp 2/8", a, bus.count); end
  endtask

  task automatic test_back_to_back();
    int ne, nv; logic en, rw;
    ne = 0; nv = 0;
    @(negedge clk);
    bus.store_req = 1'b1; bus.store_data = 17'h0beef; bus.recall_req = 1'b1; bus.recall_idx = 3'd0;
    @(posedge clk); #1;
    en = bus.mem_enable; rw = bus.mem_rw;
    ne += int'(bus.recall_err); nv += int'(bus.recall_valid);
    @(negedge clk); bus.store_req = 1'b0;
    @(posedge clk); #1;
    ne += int'(bus.recall_err); nv += int'(bus.recall_valid);
    @(negedge clk); bus.recall_req = 1'b0;
    model_store(17'h0beef);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      ne += int'(bus.recall_err); nv += int'(bus.recall_valid);
    end
    checks++; if (en !== 1'b1 || rw !== 1'b0) begin failures++; $display("FAIL conflict_store got en=%b rw=%b exp 1/0", en, rw); end
    checks++; if (ne !== 0 || nv !== 0) begin failures++; $display("FAIL conflict_dropped got err=%0d valid=%0d exp 0/0", ne, nv); end
    checks++; if (bus.count !== 4'(hist.size())) begin failures++; $display("FAIL conflict_count got=%0d exp=%0d", bus.count, hist.size()); end
  endtask

  task automatic test_clear();
    int ne, nv, lat; logic [16:0] d, din; logic [2:0] a; logic en, rw, bsy;
    apply_reset();
    for (int i = 0; i < 3; i++) op_store(17'($urandom), a, din, en, rw, bsy);
    op_clear();
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", bus.count); end
    op_recall(3'd0, ne, nv, lat, d, a, en);
    checks++; if (ne !== 1 || nv !== 0) begin failures++; $display("FAIL clear_recall got err=%0d valid=%0d exp 1/0", ne, nv); end
    op_store(17'h00777, a, din, en, rw, bsy);
    checks++; if (a !== 3'd0 || din !== 17'h00777) begin failures++; $display("FAIL clear_wptr got addr=%0d din=%h exp 0/00777", a, din); end
  endtask

  task automatic test_reset_mid();
    logic [16:0] din; logic [2:0] a; logic en, rw, bsy; int nv, ne;
    for (int p = 0; p < 2; p++) begin
      op_store(17'($urandom), a, din, en, rw, bsy);
      @(negedge clk); bus.recall_req = 1'b1; bus.recall_idx = 3'd0;
      @(posedge clk); #1;
      if (p == 1) begin
        @(negedge clk); bus.recall_req = 1'b0;
        @(posedge clk); #1;
      end
      checks++; if (bus.busy !== 1'b1 || bus.mem_enable !== (p == 0)) begin failures++; $display("FAIL midreset_pre p=%0d got busy=%b en=%b", p, bus.busy, bus.mem_enable); end
      #2; rst_n = 1'b0; bus.recall_req = 1'b0; #1;
      checks++; if (bus.busy !== 1'b0 || bus.recall_valid !== 1'b0 || bus.mem_enable !== 1'b0) begin failures++; $display("FAIL midreset_async p=%0d got busy=%b valid=%b en=%b exp 000", p, bus.busy, bus.recall_valid, bus.mem_enable); end
      checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL midreset_count p=%0d got=%0d exp=0", p, bus.count); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      nv = 0; ne = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        nv += int'(bus.recall_valid); ne += int'(bus.recall_err);
      end
      checks++; if (nv !== 0 || ne !== 0) begin failures++; $display("FAIL midreset_nopulse p=%0d got valid=%0d err=%0d exp 0/0", p, nv, ne); end
    end
  endtask

  task automatic test_random();
    int ne, nv, lat, r; logic [16:0] d, din, wd; logic [2:0] a, idx, ea; logic en, rw, bsy;
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        wd = 17'($urandom);
        ea = 3'(wptr_m);
        op_store(wd, a, din, en, rw, bsy);
        checks++; if (a !== ea || din !== wd || rw !== 1'b0) begin failures++; $display("FAIL rnd_store it=%0d got addr=%0d din=%h rw=%b exp %0d/%h/0", it, a, din, rw, ea, wd); end
        checks++; if (bus.count !== 4'(hist.size())) begin failures++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, bus.count, hist.size()); end
      end else if (r < 9) begin
        idx = 3'($urandom_range(0, 7));
        op_recall(idx, ne, nv, lat, d, a, en);
        if (int'(idx) >= hist.size()) begin
          checks++; if (ne !== 1 || nv !== 0 || en !== 1'b0) begin failures++; $display("FAIL rnd_err it=%0d idx=%0d got err=%0d valid=%0d en=%b exp 1/0/0", it, idx, ne, nv, en); end
        end else begin
          ea = 3'((wptr_m - 1 - int'(idx)) & 7);
          checks++; if (ne !== 0 || nv !== 1 || lat !== 2) begin failures++; $display("FAIL rnd_pulse it=%0d got err=%0d valid=%0d lat=%0d exp 0/1/2", it, ne, nv, lat); end
          checks++; if (d !== hist[idx] || a !== ea) begin failures++; $display("FAIL rnd_data it=%0d idx=%0d got data=%h addr=%0d exp %h/%0d", it, idx, d, a, hist[idx], ea); end
        end
      end else begin
        op_clear();
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL rnd_clear it=%0d got=%0d exp=0", it, bus.count); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 17'($urandom);
    mem_q = 'z;
    test_reset();
    test_empty_recall();
    test_store_recall();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
